// File: rtl/mul_reservation_station_pkg.sv
// Shared types and sizes for the MUL reservation station.
//   mul_op_t       : multiplier operation class
//   cdb_t          : one common-data-bus broadcast {valid, data, preg, rob_id}
//   mul_rs_entry_t : one RS slot with captured operands
package mul_reservation_station_pkg;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned PREG_W         = 6;
   localparam int unsigned ROB_W          = 5;
   localparam int unsigned MUL_RS_ENTRIES = 4;
   localparam int unsigned MUL_RS_NUM_CDB = 2;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULH   = 2'd1,
      OP_MULHSU = 2'd2,
      OP_MULHU  = 2'd3
   } mul_op_t;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   data;
      logic [PREG_W-1:0] preg;
      logic [ROB_W-1:0]  rob_id;
   } cdb_t;

   typedef struct packed {
      logic              valid;
      mul_op_t           op;
      logic [PREG_W-1:0] ps1;
      logic              rdy1;
      logic [XLEN-1:0]   v1;
      logic [PREG_W-1:0] ps2;
      logic              rdy2;
      logic [XLEN-1:0]   v2;
      logic [PREG_W-1:0] pd;
      logic [ROB_W-1:0]  rob_id;
   } mul_rs_entry_t;

endpackage

// File: rtl/mul_reservation_station_if.sv
// Dispatch, CDB snoop and multiplier-issue bundle of the MUL reservation station.
//   master : dispatch/CDB/multiplier side (drives flush, disp_*, cdb, mul_busy)
//   slave  : reservation station (drives disp_ready, iss_*)
interface mul_reservation_station_if
   import mul_reservation_station_pkg::*;
#(
   parameter int unsigned NUM_CDB = MUL_RS_NUM_CDB
);

   logic              flush;
   logic              disp_valid;
   logic              disp_ready;
   mul_op_t           disp_op;
   logic [PREG_W-1:0] disp_ps1;
   logic [PREG_W-1:0] disp_ps2;
   logic              disp_rdy1;
   logic              disp_rdy2;
   logic [XLEN-1:0]   disp_v1;
   logic [XLEN-1:0]   disp_v2;
   logic [PREG_W-1:0] disp_pd;
   logic [ROB_W-1:0]  disp_rob_id;
   cdb_t              cdb [NUM_CDB];
   logic              mul_busy;
   logic              iss_valid;
   logic [XLEN-1:0]   iss_src1;
   logic [XLEN-1:0]   iss_src2;
   mul_op_t           iss_op;
   logic [PREG_W-1:0] iss_dest_preg;
   logic [ROB_W-1:0]  iss_rob_id;

   modport master (
      output flush, disp_valid, disp_op, disp_ps1, disp_ps2, disp_rdy1, disp_rdy2,
             disp_v1, disp_v2, disp_pd, disp_rob_id, cdb, mul_busy,
      input  disp_ready, iss_valid, iss_src1, iss_src2, iss_op, iss_dest_preg, iss_rob_id
   );

   modport slave (
      input  flush, disp_valid, disp_op, disp_ps1, disp_ps2, disp_rdy1, disp_rdy2,
             disp_v1, disp_v2, disp_pd, disp_rob_id, cdb, mul_busy,
      output disp_ready, iss_valid, iss_src1, iss_src2, iss_op, iss_dest_preg, iss_rob_id
   );

endinterface

// File: rtl/mul_rs_age_matrix.sv
// Age matrix picking the oldest ready RS entry.
//   clk, rst_n   : clock, async active-low reset
//   flush        : synchronous clear of all age state
//   alloc_vec    : one-hot entry being allocated this cycle
//   free_vec     : one-hot entry being issued/freed this cycle
//   ready_vec    : entries holding both operands
//   oldest_ready : one-hot oldest ready entry (zero when none ready)
module mul_rs_age_matrix
   import mul_reservation_station_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = MUL_RS_ENTRIES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [NUM_ENTRIES-1:0] alloc_vec,
   input  logic [NUM_ENTRIES-1:0] free_vec,
   input  logic [NUM_ENTRIES-1:0] ready_vec,
   output logic [NUM_ENTRIES-1:0] oldest_ready
);

   logic [NUM_ENTRIES-1:0] r_valid;
   logic [NUM_ENTRIES-1:0] r_older [NUM_ENTRIES];  // r_older[i][j]: j is older than i

   // A new entry is younger than every surviving entry; nobody is younger-than-it yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < int'(NUM_ENTRIES); i++) r_older[i] <= '0;
      end else if (flush) begin
         r_valid <= '0;
         for (int i = 0; i < int'(NUM_ENTRIES); i++) r_older[i] <= '0;
      end else begin
         r_valid <= (r_valid & ~free_vec) | alloc_vec;
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            for (int j = 0; j < int'(NUM_ENTRIES); j++) begin
               if (alloc_vec[i])      r_older[i][j] <= r_valid[j] & ~free_vec[j];
               else if (alloc_vec[j]) r_older[i][j] <= 1'b0;
            end
         end
      end
   end

   // Oldest ready: ready with no older ready entry.
   always_comb begin
      oldest_ready = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         oldest_ready[i] = ready_vec[i] & ~(|(ready_vec & r_older[i]));
      end
   end

endmodule

// File: rtl/mul_reservation_station.sv
// Data-capturing reservation station in front of the pipelined multiplier.
//   clk, rst_n : clock, async active-low reset
//   rs (slave) : flush, dispatch handshake/payload, CDB snoop buses, mul_busy in;
//                disp_ready and issue payload (iss_*) out. Issue is selected from
//                registered entry state only, so CDB/dispatch never reach iss_* in-cycle.
module mul_reservation_station
   import mul_reservation_station_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = MUL_RS_ENTRIES,
   parameter int unsigned NUM_CDB     = MUL_RS_NUM_CDB
) (
   input  logic                      clk,
   input  logic                      rst_n,
   mul_reservation_station_if.slave  rs
);

   mul_rs_entry_t          r_ent     [NUM_ENTRIES];
   mul_rs_entry_t          w_ent_nxt [NUM_ENTRIES];
   mul_rs_entry_t          w_sel;
   logic [NUM_ENTRIES-1:0] w_valid;
   logic [NUM_ENTRIES-1:0] w_ready;
   logic [NUM_ENTRIES-1:0] w_alloc_oh;
   logic [NUM_ENTRIES-1:0] w_alloc_vec;
   logic [NUM_ENTRIES-1:0] w_iss_vec;
   logic [NUM_ENTRIES-1:0] w_oldest;
   logic                   w_disp_fire;

   always_comb begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         w_valid[i] = r_ent[i].valid;
         w_ready[i] = r_ent[i].valid & r_ent[i].rdy1 & r_ent[i].rdy2;
      end
   end

   // Lowest-index free entry from registered state; an issuing entry still counts as busy.
   always_comb begin
      w_alloc_oh = '0;
      for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
         if (!w_valid[i]) begin
            w_alloc_oh    = '0;
            w_alloc_oh[i] = 1'b1;
         end
      end
   end

   assign w_disp_fire = rs.disp_valid & ~(&w_valid);
   assign w_alloc_vec = w_disp_fire ? w_alloc_oh : '0;
   assign w_iss_vec   = rs.mul_busy ? '0 : w_oldest;

   // Next entry state: allocate or free, then snoop CDB (covers dispatch-time capture too).
   // Buses scanned high to low so the lowest matching bus wins.
   always_comb begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         w_ent_nxt[i] = r_ent[i];
         if (w_alloc_vec[i]) begin
            w_ent_nxt[i].valid  = 1'b1;
            w_ent_nxt[i].op     = rs.disp_op;
            w_ent_nxt[i].ps1    = rs.disp_ps1;
            w_ent_nxt[i].rdy1   = rs.disp_rdy1;
            w_ent_nxt[i].v1     = rs.disp_v1;
            w_ent_nxt[i].ps2    = rs.disp_ps2;
            w_ent_nxt[i].rdy2   = rs.disp_rdy2;
            w_ent_nxt[i].v2     = rs.disp_v2;
            w_ent_nxt[i].pd     = rs.disp_pd;
            w_ent_nxt[i].rob_id = rs.disp_rob_id;
         end else if (w_iss_vec[i]) begin
            w_ent_nxt[i].valid = 1'b0;
         end
         if (w_ent_nxt[i].valid && !w_ent_nxt[i].rdy1) begin
            for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
               if (rs.cdb[k].valid && (rs.cdb[k].preg == w_ent_nxt[i].ps1)) begin
                  w_ent_nxt[i].rdy1 = 1'b1;
                  w_ent_nxt[i].v1   = rs.cdb[k].data;
               end
            end
         end
         if (w_ent_nxt[i].valid && !w_ent_nxt[i].rdy2) begin
            for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
               if (rs.cdb[k].valid && (rs.cdb[k].preg == w_ent_nxt[i].ps2)) begin
                  w_ent_nxt[i].rdy2 = 1'b1;
                  w_ent_nxt[i].v2   = rs.cdb[k].data;
               end
            end
         end
      end
   end

   // Entry storage; flush beats any same-cycle dispatch or issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) r_ent[i] <= '0;
      end else if (rs.flush) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) r_ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) r_ent[i] <= w_ent_nxt[i];
      end
   end

   mul_rs_age_matrix #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_age (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (rs.flush),
      .alloc_vec    (w_alloc_vec),
      .free_vec     (w_iss_vec),
      .ready_vec    (w_ready),
      .oldest_ready (w_oldest)
   );

   // One-hot output mux; all-zero payload when nothing is ready.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (w_oldest[i]) w_sel = r_ent[i];
      end
   end

   assign rs.disp_ready    = ~(&w_valid);
   assign rs.iss_valid     = (|w_oldest) & ~rs.mul_busy;
   assign rs.iss_src1      = w_sel.v1;
   assign rs.iss_src2      = w_sel.v2;
   assign rs.iss_op        = w_sel.op;
   assign rs.iss_dest_preg = w_sel.pd;
   assign rs.iss_rob_id    = w_sel.rob_id;

endmodule

// File: tb/tb_mul_reservation_station.sv
// Self-checking bench for mul_reservation_station: scoreboard of expected issues
// (in expected issue order) checked at every negedge, plus per-scenario inline checks.
module tb_mul_reservation_station;
   import mul_reservation_station_pkg::*;

   typedef struct {
      logic [31:0] s1;
      logic [31:0] s2;
      mul_op_t     op;
      logic [5:0]  pd;
      logic [4:0]  rob;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   mul_reservation_station_if #(.NUM_CDB(2)) rs_if ();

   mul_reservation_station #(.NUM_ENTRIES(4), .NUM_CDB(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rs    (rs_if)
   );

   // Scoreboard monitor: every issue must match the next expected op.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rs_if.iss_valid === 1'b1) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_issue: got rob=%0d src1=%h, scoreboard empty",
                     rs_if.iss_rob_id, rs_if.iss_src1);
         end else begin
            mon_e = sb_q.pop_front();
            if ({rs_if.iss_src1, rs_if.iss_src2, rs_if.iss_op, rs_if.iss_dest_preg, rs_if.iss_rob_id}
                !== {mon_e.s1, mon_e.s2, mon_e.op, mon_e.pd, mon_e.rob}) begin
               tests_failed++;
               $display("FAIL sb_issue: got src1=%h src2=%h op=%0d pd=%0d rob=%0d, want src1=%h src2=%h op=%0d pd=%0d rob=%0d",
                        rs_if.iss_src1, rs_if.iss_src2, rs_if.iss_op, rs_if.iss_dest_preg, rs_if.iss_rob_id,
                        mon_e.s1, mon_e.s2, mon_e.op, mon_e.pd, mon_e.rob);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cdb();
      for (int k = 0; k < 2; k++) rs_if.cdb[k] = '0;
   endtask

   task automatic idle_inputs();
      rs_if.flush       = 1'b0;
      rs_if.disp_valid  = 1'b0;
      rs_if.disp_op     = OP_MUL;
      rs_if.disp_ps1    = '0;
      rs_if.disp_ps2    = '0;
      rs_if.disp_rdy1   = 1'b0;
      rs_if.disp_rdy2   = 1'b0;
      rs_if.disp_v1     = '0;
      rs_if.disp_v2     = '0;
      rs_if.disp_pd     = '0;
      rs_if.disp_rob_id = '0;
      rs_if.mul_busy    = 1'b0;
      clear_cdb();
   endtask

   task automatic drive_disp(input mul_op_t op, input logic [5:0] ps1, input logic r1,
                             input logic [31:0] v1, input logic [5:0] ps2, input logic r2,
                             input logic [31:0] v2, input logic [5:0] pd, input logic [4:0] rob);
      rs_if.disp_valid  = 1'b1;
      rs_if.disp_op     = op;
      rs_if.disp_ps1    = ps1;
      rs_if.disp_rdy1   = r1;
      rs_if.disp_v1     = v1;
      rs_if.disp_ps2    = ps2;
      rs_if.disp_rdy2   = r2;
      rs_if.disp_v2     = v2;
      rs_if.disp_pd     = pd;
      rs_if.disp_rob_id = rob;
   endtask

   task automatic drive_cdb(input int k, input logic [5:0] preg, input logic [31:0] data);
      cdb_t c;
      c.valid  = 1'b1;
      c.data   = data;
      c.preg   = preg;
      c.rob_id = 5'd0;
      rs_if.cdb[k] = c;
   endtask

   task automatic sb_push(input logic [31:0] s1, input logic [31:0] s2, input mul_op_t op,
                          input logic [5:0] pd, input logic [4:0] rob);
      exp_t e;
      e.s1 = s1; e.s2 = s2; e.op = op; e.pd = pd; e.rob = rob;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      tests_run++;
      if (rs_if.disp_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_disp_ready: got %b want 1", rs_if.disp_ready);
      end
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_iss_valid: got %b want 0", rs_if.iss_valid);
      end
      tests_run++;
      if ({rs_if.iss_src1, rs_if.iss_src2, rs_if.iss_dest_preg, rs_if.iss_rob_id} !== 75'd0) begin
         tests_failed++; $display("FAIL reset_iss_data: got src1=%h src2=%h pd=%0d rob=%0d want all 0",
                                  rs_if.iss_src1, rs_if.iss_src2, rs_if.iss_dest_preg, rs_if.iss_rob_id);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_issue();
      drive_disp(OP_MUL, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd6, 6'd3, 5'd1);
      sb_push(32'd7, 32'd6, OP_MUL, 6'd3, 5'd1);
      #1;
      tests_run++;
      if (rs_if.disp_ready !== 1'b1) begin
         tests_failed++; $display("FAIL t1_disp_ready: got %b want 1", rs_if.disp_ready);
      end
      tick();
      rs_if.disp_valid = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_src1, rs_if.iss_src2} !== {1'b1, 32'd7, 32'd6}) begin
         tests_failed++; $display("FAIL t1_issue: got valid=%b src1=%0d src2=%0d want 1/7/6",
                                  rs_if.iss_valid, rs_if.iss_src1, rs_if.iss_src2);
      end
      tick();
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t1_freed: got iss_valid=%b want 0", rs_if.iss_valid);
      end
   endtask

   task automatic test_cdb_wakeup();
      drive_disp(OP_MULH, 6'd12, 1'b0, 32'd0, 6'd2, 1'b1, 32'h3, 6'd4, 5'd2);
      sb_push(32'h5, 32'h3, OP_MULH, 6'd4, 5'd2);
      tick();
      rs_if.disp_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests_run++;
         if (rs_if.iss_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t2_wait: cycle %0d got iss_valid=%b want 0", c, rs_if.iss_valid);
         end
         tick();
      end
      drive_cdb(1, 6'd12, 32'h5);
      #1;
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t2_no_comb_path: got iss_valid=%b want 0", rs_if.iss_valid);
      end
      tick();
      clear_cdb();
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_src1} !== {1'b1, 32'h5}) begin
         tests_failed++; $display("FAIL t2_issue_after_bcast: got valid=%b src1=%h want 1/5",
                                  rs_if.iss_valid, rs_if.iss_src1);
      end
      tick();
   endtask

   task automatic test_cdb_priority();
      drive_disp(OP_MULHU, 6'd1, 1'b1, 32'h2, 6'd20, 1'b0, 32'd0, 6'd5, 5'd3);
      sb_push(32'h2, 32'hAAAA, OP_MULHU, 6'd5, 5'd3);
      tick();
      rs_if.disp_valid = 1'b0;
      drive_cdb(0, 6'd20, 32'hAAAA);
      drive_cdb(1, 6'd20, 32'hBBBB);
      tick();
      clear_cdb();
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_src2} !== {1'b1, 32'hAAAA}) begin
         tests_failed++; $display("FAIL cdb_lowest_bus_wins: got valid=%b src2=%h want 1/aaaa",
                                  rs_if.iss_valid, rs_if.iss_src2);
      end
      tick();
   endtask

   task automatic test_dispatch_capture();
      drive_disp(OP_MULHSU, 6'd1, 1'b1, 32'd11, 6'd9, 1'b0, 32'd0, 6'd6, 5'd4);
      drive_cdb(0, 6'd9, 32'h99);
      sb_push(32'd11, 32'h99, OP_MULHSU, 6'd6, 5'd4);
      tick();
      rs_if.disp_valid = 1'b0;
      clear_cdb();
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_src2} !== {1'b1, 32'h99}) begin
         tests_failed++; $display("FAIL t3_capture: got valid=%b src2=%h want 1/99",
                                  rs_if.iss_valid, rs_if.iss_src2);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [4:0] robs [4]    = '{5'd30, 5'd31, 5'd0, 5'd1};
      logic [4:0] exp_rob [4] = '{5'd31, 5'd0, 5'd1, 5'd2};
      rs_if.mul_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_disp(OP_MUL, 6'(i + 1), 1'b1, 32'(100 + i), 6'd2, 1'b1, 32'(200 + i), 6'(10 + i), robs[i]);
         sb_push(32'(100 + i), 32'(200 + i), OP_MUL, 6'(10 + i), robs[i]);
         tick();
      end
      rs_if.disp_valid = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.disp_ready, rs_if.iss_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL t4_full_busy: got disp_ready=%b iss_valid=%b want 0/0",
                                  rs_if.disp_ready, rs_if.iss_valid);
      end
      tick();
      rs_if.mul_busy = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_rob_id, rs_if.disp_ready} !== {1'b1, 5'd30, 1'b0}) begin
         tests_failed++; $display("FAIL t4_first_issue: got valid=%b rob=%0d disp_ready=%b want 1/30/0",
                                  rs_if.iss_valid, rs_if.iss_rob_id, rs_if.disp_ready);
      end
      tick();
      rs_if.mul_busy = 1'b1;
      drive_disp(OP_MUL, 6'd5, 1'b1, 32'd104, 6'd2, 1'b1, 32'd204, 6'd14, 5'd2);
      sb_push(32'd104, 32'd204, OP_MUL, 6'd14, 5'd2);
      #1;
      tests_run++;
      if (rs_if.disp_ready !== 1'b1) begin
         tests_failed++; $display("FAIL t4_slot_reuse: got disp_ready=%b want 1", rs_if.disp_ready);
      end
      tick();
      rs_if.disp_valid = 1'b0;
      rs_if.mul_busy   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests_run++;
         if ({rs_if.iss_valid, rs_if.iss_rob_id} !== {1'b1, exp_rob[i]}) begin
            tests_failed++; $display("FAIL t4_age_order: slot %0d got valid=%b rob=%0d want 1/%0d",
                                     i, rs_if.iss_valid, rs_if.iss_rob_id, exp_rob[i]);
         end
         tick();
      end
      #1;
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t4_drained: got iss_valid=%b want 0", rs_if.iss_valid);
      end
   endtask

   task automatic test_age_order();
      rs_if.mul_busy = 1'b1;
      drive_disp(OP_MUL, 6'd1, 1'b1, 32'h31, 6'd2, 1'b1, 32'h32, 6'd20, 5'd3);
      sb_push(32'h31, 32'h32, OP_MUL, 6'd20, 5'd3);
      tick();
      drive_disp(OP_MULH, 6'd40, 1'b0, 32'd0, 6'd2, 1'b1, 32'h52, 6'd21, 5'd5);
      tick();
      drive_disp(OP_MULHU, 6'd1, 1'b1, 32'h61, 6'd2, 1'b1, 32'h62, 6'd22, 5'd6);
      sb_push(32'h61, 32'h62, OP_MULHU, 6'd22, 5'd6);
      tick();
      rs_if.disp_valid = 1'b0;
      rs_if.mul_busy   = 1'b0;
      tick();
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_rob_id} !== {1'b1, 5'd6}) begin
         tests_failed++; $display("FAIL t5_younger_ready_first: got valid=%b rob=%0d want 1/6",
                                  rs_if.iss_valid, rs_if.iss_rob_id);
      end
      tick();
      rs_if.mul_busy = 1'b1;
      drive_disp(OP_MULHSU, 6'd1, 1'b1, 32'h71, 6'd2, 1'b1, 32'h72, 6'd23, 5'd7);
      drive_cdb(0, 6'd40, 32'h51);
      sb_push(32'h51, 32'h52, OP_MULH, 6'd21, 5'd5);
      sb_push(32'h71, 32'h72, OP_MULHSU, 6'd23, 5'd7);
      tick();
      rs_if.disp_valid = 1'b0;
      clear_cdb();
      #1;
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t5_busy_hold: got iss_valid=%b want 0", rs_if.iss_valid);
      end
      rs_if.mul_busy = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_rob_id} !== {1'b1, 5'd5}) begin
         tests_failed++; $display("FAIL t5_woken_oldest_first: got valid=%b rob=%0d want 1/5",
                                  rs_if.iss_valid, rs_if.iss_rob_id);
      end
      tick();
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_rob_id} !== {1'b1, 5'd7}) begin
         tests_failed++; $display("FAIL t5_youngest_last: got valid=%b rob=%0d want 1/7",
                                  rs_if.iss_valid, rs_if.iss_rob_id);
      end
      tick();
   endtask

   task automatic test_flush_reset();
      rs_if.mul_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_disp(OP_MUL, 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(i), 6'd30, 5'(20 + i));
         tick();
      end
      drive_disp(OP_MUL, 6'd1, 1'b1, 32'hF, 6'd2, 1'b1, 32'hF, 6'd31, 5'd23);
      rs_if.flush = 1'b1;
      tick();
      rs_if.disp_valid = 1'b0;
      rs_if.flush      = 1'b0;
      rs_if.mul_busy   = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.disp_ready} !== 2'b01) begin
         tests_failed++; $display("FAIL t6_flush: got iss_valid=%b disp_ready=%b want 0/1",
                                  rs_if.iss_valid, rs_if.disp_ready);
      end
      tick();
      tests_run++;
      if (rs_if.iss_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t6_flush_drops_dispatch: got iss_valid=%b want 0", rs_if.iss_valid);
      end
      rs_if.mul_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive_disp(OP_MULH, 6'd1, 1'b1, 32'h40, 6'd2, 1'b1, 32'h41, 6'd32, 5'(24 + i));
         tick();
      end
      rs_if.disp_valid = 1'b0;
      #2 rst_n = 1'b0;
      rs_if.mul_busy = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.disp_ready} !== 2'b01) begin
         tests_failed++; $display("FAIL t6_async_reset: got iss_valid=%b disp_ready=%b want 0/1",
                                  rs_if.iss_valid, rs_if.disp_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      drive_disp(OP_MUL, 6'd1, 1'b1, 32'h1234, 6'd2, 1'b1, 32'h10, 6'd33, 5'd9);
      sb_push(32'h1234, 32'h10, OP_MUL, 6'd33, 5'd9);
      tick();
      rs_if.disp_valid = 1'b0;
      #1;
      tests_run++;
      if ({rs_if.iss_valid, rs_if.iss_rob_id} !== {1'b1, 5'd9}) begin
         tests_failed++; $display("FAIL t6_post_reset_issue: got valid=%b rob=%0d want 1/9",
                                  rs_if.iss_valid, rs_if.iss_rob_id);
      end
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic_issue();
      test_cdb_wakeup();
      test_cdb_priority();
      test_dispatch_capture();
      test_back_to_back();
      test_age_order();
      test_flush_reset();
      tick();
      tests_run++;
      if (sb_q.size() != 0) begin
         tests_failed++; $display("FAIL sb_drain: got %0d pending issues want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
